// File: rtl/memcpy_dma.sv
// memcpy_dma: multi-lane DMA copy/fill engine.
// Moves a block of bytes through a LANES-wide byte-lane DRAM port, one chunk
// of up to LANES bytes per read/write beat pair. COPY runs in descending
// order when the destination overlaps the tail of the source, so the move is
// overlap-safe. FILL writes a constant byte and issues no reads.
module memcpy_dma #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 64,
    parameter int SIZE_W = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mode,
    input  logic [ADDR_W-1:0]       src,
    input  logic [ADDR_W-1:0]       dst,
    input  logic [SIZE_W-1:0]       size,
    input  logic [7:0]              fill_byte,
    output logic                    busy,
    output logic                    done,
    output logic [LANES-1:0]        dram_en,
    output logic                    dram_rdwr,
    output logic [LANES*ADDR_W-1:0] dram_addr,
    output logic [LANES*8-1:0]      dram_data_out,
    input  logic [LANES*8-1:0]      dram_data_in,
    input  logic [LANES-1:0]        dram_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_GAP_RW,
        S_WR,
        S_GAP_WR,
        S_DONE
    } state_t;

    typedef logic [ADDR_W:0] addr_ext_t;

    localparam logic [SIZE_W-1:0] LANES_SZ = SIZE_W'(LANES);

    state_t               state, state_nxt;

    // Latched command.
    logic                 mode_q;
    logic                 desc_q;
    logic [ADDR_W-1:0]    src_q;
    logic [ADDR_W-1:0]    dst_q;
    logic [SIZE_W-1:0]    size_q;
    logic [7:0]           fill_q;
    logic [SIZE_W-1:0]    remaining_q;

    // Per-beat lane tracking and captured read data.
    logic [LANES-1:0]     seen_q;
    logic [LANES*8-1:0]   cap_q;

    logic [SIZE_W-1:0]    chunk_n;
    logic [SIZE_W-1:0]    chunk_off;
    logic [LANES-1:0]     lane_mask;
    logic [LANES-1:0]     seen_nxt;
    logic                 all_seen;
    logic                 desc_in;

    // Chunk geometry, sticky lane completion and copy direction of a new command.
    // NOTE: every variable of an always_comb gets a value on every path (here
    // by straight-line assignment, in the FSM below by defaults first), so no
    // latch is inferred.
    always_comb begin
        chunk_n   = (remaining_q < LANES_SZ) ? remaining_q : LANES_SZ;
        chunk_off = desc_q ? (remaining_q - chunk_n) : (size_q - remaining_q);
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (SIZE_W'(i) < chunk_n);
        end
        seen_nxt = seen_q | (dram_valid & lane_mask);
        all_seen = (seen_nxt == lane_mask);
        desc_in  = !mode
                   && ({1'b0, dst} > {1'b0, src})
                   && ({1'b0, dst} < ({1'b0, src} + addr_ext_t'(size)));
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and DRAM port outputs.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        dram_en       = '0;
        dram_rdwr     = 1'b0;
        dram_addr     = '0;
        dram_data_out = '0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    if (size == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = mode ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                busy    = 1'b1;
                dram_en = lane_mask;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_mask[i]) begin
                        dram_addr[i*ADDR_W +: ADDR_W] = src_q + ADDR_W'(chunk_off) + ADDR_W'(i);
                    end
                end
                if (all_seen) state_nxt = S_GAP_RW;
            end
            S_GAP_RW: begin
                busy      = 1'b1;
                state_nxt = S_WR;
            end
            S_WR: begin
                busy      = 1'b1;
                dram_en   = lane_mask;
                dram_rdwr = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_mask[i]) begin
                        dram_addr[i*ADDR_W +: ADDR_W] = dst_q + ADDR_W'(chunk_off) + ADDR_W'(i);
                        dram_data_out[i*8 +: 8]       = mode_q ? fill_q : cap_q[i*8 +: 8];
                    end
                end
                if (all_seen) state_nxt = S_GAP_WR;
            end
            S_GAP_WR: begin
                busy = 1'b1;
                if (remaining_q == chunk_n) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = mode_q ? S_WR : S_RD;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!en) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch, lane tracking, read-data capture and progress counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= 1'b0;
            desc_q      <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            size_q      <= '0;
            fill_q      <= '0;
            remaining_q <= '0;
            seen_q      <= '0;
            cap_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        mode_q      <= mode;
                        desc_q      <= desc_in;
                        src_q       <= src;
                        dst_q       <= dst;
                        size_q      <= size;
                        fill_q      <= fill_byte;
                        remaining_q <= size;
                        seen_q      <= '0;
                    end
                end
                S_RD: begin
                    seen_q <= all_seen ? '0 : seen_nxt;
                    for (int i = 0; i < LANES; i++) begin
                        if (dram_valid[i] && lane_mask[i] && !seen_q[i]) begin
                            cap_q[i*8 +: 8] <= dram_data_in[i*8 +: 8];
                        end
                    end
                end
                S_WR: begin
                    seen_q <= all_seen ? '0 : seen_nxt;
                end
                S_GAP_WR: begin
                    remaining_q <= remaining_q - chunk_n;
                end
                default: ;
            endcase
        end
    end

endmodule
